// File: rtl/adc_spi_responder_pkg.sv
// Shared constants for the ADC SPI responder and its master.
// State codes, default resolution and command frame layout.
package adc_spi_pkg;

  localparam int RES_DEF = 12;

  // Command bit order on sdi, first bit sent first
  localparam int CMD_START = 0;
  localparam int CMD_SGL   = 1;
  localparam int CMD_ODD   = 2;
  localparam int CMD_MSBF  = 3;
  localparam int CMD_LEN   = 4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SGL   = 3'd1;
  localparam logic [2:0] ST_ODD   = 3'd2;
  localparam logic [2:0] ST_MSBF  = 3'd3;
  localparam logic [2:0] ST_NULLB = 3'd4;
  localparam logic [2:0] ST_DATA  = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;
  localparam logic [2:0] ST_LSBF  = 3'd7;

endpackage

// File: rtl/adc_spi_responder_if.sv
// Three-wire SPI bus between the ADC master FSM and a responder.
// Clock (sck) and reset stay plain ports on the modules.
interface adc_spi_if;

  logic cs;
  logic sdi;
  logic sdo;

  modport master (output cs, output sdi, input sdo);
  modport slave  (input cs, input sdi, output sdo);

endinterface

// File: rtl/adc_shift_out.sv
// Loadable rotating shift register with direction select and bit counter.
// Rotation keeps the operand intact so it can be replayed LSB-first.
import adc_spi_pkg::*;

module adc_shift_out #(
  parameter int RES = RES_DEF
) (
  input  logic                   sck,
  input  logic                   reset,
  input  logic                   load,
  input  logic [RES-1:0]         din,
  input  logic                   shift_en,
  input  logic                   lsbf,
  input  logic                   cnt_clr,
  output logic                   sbit,
  output logic [$clog2(RES)-1:0] cnt
);

  logic [RES-1:0] shreg;

  // Load, rotate and count on each sck edge
  always_ff @(posedge sck or negedge reset) begin
    if (!reset) begin
      shreg <= '0;
      cnt   <= '0;
    end else begin
      if (load)
        shreg <= din;
      else if (shift_en)
        shreg <= lsbf ? {shreg[0], shreg[RES-1:1]}
                      : {shreg[RES-2:0], shreg[RES-1]};
      if (cnt_clr)
        cnt <= '0;
      else if (shift_en)
        cnt <= cnt + 1'b1;
    end
  end

  assign sbit = lsbf ? shreg[0] : shreg[RES-1];

endmodule

// File: rtl/adc_spi_responder.sv
// SPI responder emulating a 2-channel serial ADC for master bring-up.
// Optional ADC_LSBF_REPEAT_EN replays the sample LSB-first when MSBF=0.
import adc_spi_pkg::*;

module adc_spi_responder #(
  parameter int RES = RES_DEF
) (
  input  logic           sck,
  input  logic           reset,
  adc_spi_if.slave       spi,
  input  logic [RES-1:0] sample_ch0,
  input  logic [RES-1:0] sample_ch1,
  output logic           frame_done,
  output logic           frame_abort,
  output logic           cfg_sgl,
  output logic           cfg_odd
);

  localparam int CW = $clog2(RES);
  localparam logic [CW-1:0] LAST_D = CW'(RES - 1);
  localparam logic [CW-1:0] LAST_L = CW'(RES - 2);

  logic [2:0]     state;
  logic [RES-1:0] operand;
  logic [RES:0]   d01;
  logic [RES:0]   d10;
  logic           load;
  logic           shift_en;
  logic           cnt_clr;
  logic           lsbf_dir;
  logic           sbit;
  logic [CW-1:0]  cnt;
`ifdef ADC_LSBF_REPEAT_EN
  logic           msbf;
`endif

  assign d01 = {1'b0, sample_ch0} - {1'b0, sample_ch1};
  assign d10 = {1'b0, sample_ch1} - {1'b0, sample_ch0};

  // Operand selection with negative differences clamped to zero
  always_comb begin
    operand = '0;
    unique case (1'b1)
      cfg_sgl & ~cfg_odd:  operand = sample_ch0;
      cfg_sgl &  cfg_odd:  operand = sample_ch1;
      ~cfg_sgl & ~cfg_odd: operand = d01[RES] ? '0 : d01[RES-1:0];
      default:             operand = d10[RES] ? '0 : d10[RES-1:0];
    endcase
  end

  // Shifter controls; the last DATA edge holds so LSBF starts at bit 1
  always_comb begin
    load     = ~spi.cs & (state == ST_MSBF);
    lsbf_dir = (state == ST_LSBF);
    cnt_clr  = (state == ST_NULLB) |
               ((state == ST_DATA) & (cnt == LAST_D));
    shift_en = ((state == ST_DATA) & (cnt != LAST_D)) | lsbf_dir;
  end

  assign spi.sdo = ~spi.cs & sbit &
                   ((state == ST_DATA) | (state == ST_LSBF));

  // Command decode, frame sequencing and status pulses
  always_ff @(posedge sck or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      cfg_sgl     <= 1'b0;
      cfg_odd     <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
`ifdef ADC_LSBF_REPEAT_EN
      msbf        <= 1'b0;
`endif
    end else begin
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      if (spi.cs) begin
        if (state != ST_IDLE && state != ST_DONE)
          frame_abort <= 1'b1;
        state <= ST_IDLE;
      end else begin
        unique case (state)
          ST_IDLE:  if (spi.sdi) state <= ST_SGL;
          ST_SGL: begin
            cfg_sgl <= spi.sdi;
            state   <= ST_ODD;
          end
          ST_ODD: begin
            cfg_odd <= spi.sdi;
            state   <= ST_MSBF;
          end
          ST_MSBF: begin
`ifdef ADC_LSBF_REPEAT_EN
            msbf  <= spi.sdi;
`endif
            state <= ST_NULLB;
          end
          ST_NULLB: state <= ST_DATA;
          ST_DATA: begin
            if (cnt == LAST_D) begin
`ifdef ADC_LSBF_REPEAT_EN
              state      <= msbf ? ST_DONE : ST_LSBF;
              frame_done <= msbf;
`else
              state      <= ST_DONE;
              frame_done <= 1'b1;
`endif
            end
          end
`ifdef ADC_LSBF_REPEAT_EN
          ST_LSBF: begin
            if (cnt == LAST_L) begin
              state      <= ST_DONE;
              frame_done <= 1'b1;
            end
          end
`endif
          ST_DONE:  state <= ST_DONE;
          default:  state <= ST_IDLE;
        endcase
      end
    end
  end

  adc_shift_out #(.RES(RES)) u_shift (
    .sck      (sck),
    .reset    (reset),
    .load     (load),
    .din      (operand),
    .shift_en (shift_en),
    .lsbf     (lsbf_dir),
    .cnt_clr  (cnt_clr),
    .sbit     (sbit),
    .cnt      (cnt)
  );

endmodule
